// File: rtl/mdu_sched.sv
// Shared MULT/MULTU/DIV/DIVU sequencer for the c and p execute pipes.
// One operation at a time; c wins simultaneous requests, done pulses for the owner.
module mdu_sched #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        c_req,
  input  logic [1:0]  c_op,
  input  logic [31:0] c_src_a,
  input  logic [31:0] c_src_b,
  output logic        c_done,
  output logic        c_stall_req,
  input  logic        p_req,
  input  logic [1:0]  p_op,
  input  logic [31:0] p_src_a,
  input  logic [31:0] p_src_b,
  output logic        p_done,
  output logic        p_stall_req,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] dvs_q, rem_q, dq_q;
  logic [5:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic        owner_q;

  logic        grant;
  logic [1:0]  sel_op;
  logic [31:0] sel_a, sel_b, abs_a, abs_b;
  logic        sel_sgn, sgn_q;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] rem_shift, diff;
  logic        q_bit;
  logic [31:0] rem_next, dq_next;
  logic        div_zero, neg_q, neg_r;
  logic [31:0] div_hi, div_lo;
  logic        mul_last, div_last;

  assign grant   = (state_q == S_IDLE) && !flush && (c_req || p_req);
  assign sel_op  = c_req ? c_op    : p_op;
  assign sel_a   = c_req ? c_src_a : p_src_a;
  assign sel_b   = c_req ? c_src_b : p_src_b;
  assign sel_sgn = ~sel_op[0];
  assign abs_a   = (sel_sgn && sel_a[31]) ? ('0 - sel_a) : sel_a;
  assign abs_b   = (sel_sgn && sel_b[31]) ? ('0 - sel_b) : sel_b;
  assign sgn_q   = ~op_q[0];

  // Sign-extending to 64 bits makes the truncated product correct for both signednesses.
  assign mul_a   = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b   = {{32{sgn_q & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

  // Restoring step: dividend bits shift out of dq_q while quotient bits shift in.
  assign rem_shift = {rem_q, dq_q[31]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~diff[32];
  assign rem_next  = q_bit ? diff[31:0] : rem_shift[31:0];
  assign dq_next   = {dq_q[30:0], q_bit};

  assign div_zero = (b_q == '0);
  assign neg_q    = sgn_q & (a_q[31] ^ b_q[31]);
  assign neg_r    = sgn_q & a_q[31];
  assign div_lo   = div_zero ? '1  : (neg_q ? ('0 - dq_next)  : dq_next);
  assign div_hi   = div_zero ? a_q : (neg_r ? ('0 - rem_next) : rem_next);

  assign mul_last = (cnt_q == MUL_LAST);
  assign div_last = (cnt_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (c_req || p_req) state_d = sel_op[1] ? S_DIV : S_MUL;
        S_MUL:  if (mul_last) state_d = S_DONE;
        S_DIV:  if (div_last) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      owner_q <= 1'b0;
    end else if (grant) begin
      owner_q <= ~c_req;
      op_q    <= sel_op;
      a_q     <= sel_a;
      b_q     <= sel_b;
      dq_q    <= abs_a;
      dvs_q   <= abs_b;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else if (!flush) begin
      if (state_q == S_MUL) begin
        cnt_q <= mul_last ? '0 : cnt_q + 6'd1;
        if (mul_last) begin
          hi_q <= product[63:32];
          lo_q <= product[31:0];
        end
      end else if (state_q == S_DIV) begin
        rem_q <= rem_next;
        dq_q  <= dq_next;
        cnt_q <= div_last ? '0 : cnt_q + 6'd1;
        if (div_last) begin
          hi_q <= div_hi;
          lo_q <= div_lo;
        end
      end
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    c_done      = (state_q == S_DONE) && !owner_q;
    p_done      = (state_q == S_DONE) &&  owner_q;
    owner       = owner_q;
    hi_res      = hi_q;
    lo_res      = lo_q;
    c_stall_req = c_req & ~c_done;
    p_stall_req = p_req & ~p_done;
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency, arithmetic corner cases, arbitration, flush, reset.
module tb_mdu_sched;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        c_req, p_req;
  logic [1:0]  c_op, p_op;
  logic [31:0] c_src_a, c_src_b, p_src_a, p_src_b;
  logic        c_done, c_stall_req, p_done, p_stall_req;
  logic [31:0] hi_res, lo_res;
  logic        busy, owner;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_sched #(.MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .c_req(c_req), .c_op(c_op), .c_src_a(c_src_a), .c_src_b(c_src_b),
    .c_done(c_done), .c_stall_req(c_stall_req),
    .p_req(p_req), .p_op(p_op), .p_src_a(p_src_a), .p_src_b(p_src_b),
    .p_done(p_done), .p_stall_req(p_stall_req),
    .hi_res(hi_res), .lo_res(lo_res), .busy(busy), .owner(owner)
  );

  // Issue one request from the current (IDLE) cycle and wait, bounded, for its done.
  task automatic do_op(input logic pipe, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic [31:0] hi, output logic [31:0] lo);
    cyc = -1; hi = '0; lo = '0;
    if (!pipe) begin c_req = 1'b1; c_op = op; c_src_a = a; c_src_b = b; end
    else       begin p_req = 1'b1; p_op = op; p_src_a = a; p_src_b = b; end
    for (int k = 1; k <= 100 && cyc < 0; k++) begin
      @(negedge clk);
      if ((pipe ? p_done : c_done) === 1'b1) begin cyc = k; hi = hi_res; lo = lo_res; end
    end
    c_req = 1'b0; p_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; c_req = 1'b0; p_req = 1'b0;
    c_op = '0; p_op = '0; c_src_a = '0; c_src_b = '0; p_src_a = '0; p_src_b = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (c_done !== 1'b0) begin bad++; $display("FAIL reset_c_done: got %b want 0", c_done); end
    total++; if (p_done !== 1'b0) begin bad++; $display("FAIL reset_p_done: got %b want 0", p_done); end
    total++; if (owner !== 1'b0)  begin bad++; $display("FAIL reset_owner: got %b want 0", owner); end
    total++; if (hi_res !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi_res); end
    total++; if (lo_res !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo_res); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    c_req = 1'b1; c_op = 2'b00; c_src_a = 32'hFFFF_FFFE; c_src_b = 32'd3;
    #1;
    total++; if (c_stall_req !== 1'b1) begin bad++; $display("FAIL mult_stall_c0: got %b want 1", c_stall_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_c0: got %b want 0", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy_c1: got %b want 1", busy); end
    total++; if (c_done !== 1'b0) begin bad++; $display("FAIL mult_done_c1: got %b want 0", c_done); end
    total++; if (c_stall_req !== 1'b1) begin bad++; $display("FAIL mult_stall_c1: got %b want 1", c_stall_req); end
    @(negedge clk);
    total++; if (c_done !== 1'b1) begin bad++; $display("FAIL mult_done_c2: got %b want 1", c_done); end
    total++; if (p_done !== 1'b0) begin bad++; $display("FAIL mult_pdone_c2: got %b want 0", p_done); end
    total++; if (c_stall_req !== 1'b0) begin bad++; $display("FAIL mult_stall_c2: got %b want 0", c_stall_req); end
    total++; if (hi_res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi_res); end
    total++; if (lo_res !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo: got %h want fffffffa", lo_res); end
    c_req = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_c3: got %b want 0", busy); end
    total++; if (c_done !== 1'b0) begin bad++; $display("FAIL mult_done_c3: got %b want 0", c_done); end
  endtask

  task automatic test_divu;
    p_req = 1'b1; p_op = 2'b11; p_src_a = 32'd100; p_src_b = 32'd7;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL divu_busy c%0d: got %b want 1", k, busy); end
      total++; if (p_done !== (k == 33)) begin bad++; $display("FAIL divu_done c%0d: got %b want %b", k, p_done, (k == 33)); end
      if (k == 1) begin
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL divu_owner: got %b want 1", owner); end
      end
    end
    total++; if (lo_res !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want 0000000e", lo_res); end
    total++; if (hi_res !== 32'd2)  begin bad++; $display("FAIL divu_hi: got %h want 00000002", hi_res); end
    total++; if (p_stall_req !== 1'b0) begin bad++; $display("FAIL divu_stall_done: got %b want 0", p_stall_req); end
    p_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_signed;
    int cyc;
    logic [31:0] hi, lo;
    do_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, cyc, hi, lo);
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_neg7_lat: got %0d want 33", cyc); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg7_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg7_hi: got %h want ffffffff", hi); end
    @(negedge clk);
    do_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, hi, lo);
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_ovf_lat: got %0d want 33", cyc); end
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    @(negedge clk);
    do_op(1'b1, 2'b10, 32'hFFFF_FFFB, 32'd0, cyc, hi, lo);
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_zero_lat: got %0d want 33", cyc); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_zero_lo: got %h want ffffffff", lo); end
    total++; if (hi !== 32'hFFFF_FFFB) begin bad++; $display("FAIL div_zero_hi: got %h want fffffffb", hi); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    c_req = 1'b1; c_op = 2'b01; c_src_a = 32'hFFFF_FFFF; c_src_b = 32'hFFFF_FFFF;
    p_req = 1'b1; p_op = 2'b11; p_src_a = 32'd10; p_src_b = 32'd0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 2) begin
        total++; if (c_done !== 1'b1) begin bad++; $display("FAIL b2b_c_done: got %b want 1", c_done); end
        total++; if (hi_res !== 32'hFFFF_FFFE) begin bad++; $display("FAIL b2b_c_hi: got %h want fffffffe", hi_res); end
        total++; if (lo_res !== 32'h1) begin bad++; $display("FAIL b2b_c_lo: got %h want 00000001", lo_res); end
        total++; if (p_stall_req !== 1'b1) begin bad++; $display("FAIL b2b_p_stall_c2: got %b want 1", p_stall_req); end
        c_req = 1'b0;
      end
      if (k == 3) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_c3: got %b want 0", busy); end
        total++; if (p_stall_req !== 1'b1) begin bad++; $display("FAIL b2b_p_stall_c3: got %b want 1", p_stall_req); end
      end
      if (k == 4) begin
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL b2b_owner_c4: got %b want 1", owner); end
      end
      if (k == 35) begin
        total++; if (p_done !== 1'b0) begin bad++; $display("FAIL b2b_p_early: got %b want 0", p_done); end
      end
    end
    total++; if (p_done !== 1'b1) begin bad++; $display("FAIL b2b_p_done: got %b want 1", p_done); end
    total++; if (lo_res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_p_lo: got %h want ffffffff", lo_res); end
    total++; if (hi_res !== 32'd10) begin bad++; $display("FAIL b2b_p_hi: got %h want 0000000a", hi_res); end
    p_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush;
    int cyc;
    logic [31:0] hi, lo;
    p_req = 1'b1; p_op = 2'b10; p_src_a = 32'd1000; p_src_b = 32'hFFFF_FFFD;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      total++; if (p_done !== 1'b0) begin bad++; $display("FAIL flush_p_done c%0d: got %b want 0", k, p_done); end
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; p_req = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    total++; if (p_done !== 1'b0) begin bad++; $display("FAIL flush_no_done: got %b want 0", p_done); end
    total++; if (hi_res !== 32'd10) begin bad++; $display("FAIL flush_hi_hold: got %h want 0000000a", hi_res); end
    total++; if (lo_res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush_lo_hold: got %h want ffffffff", lo_res); end
    do_op(1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD, cyc, hi, lo);
    total++; if (cyc !== 2) begin bad++; $display("FAIL flush_next_lat: got %0d want 2", cyc); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush_next_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL flush_next_lo: got %h want ffffffeb", lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [31:0] hi, lo;
    p_req = 1'b1; p_op = 2'b10; p_src_a = 32'd12345; p_src_b = 32'hFFFF_FFEF;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (hi_res !== 32'h0) begin bad++; $display("FAIL rstmid_hi: got %h want 0", hi_res); end
    total++; if (lo_res !== 32'h0) begin bad++; $display("FAIL rstmid_lo: got %h want 0", lo_res); end
    total++; if (p_done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", p_done); end
    p_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op(1'b0, 2'b00, 32'd5, 32'd6, cyc, hi, lo);
    total++; if (cyc !== 2) begin bad++; $display("FAIL rstmid_mul_lat: got %0d want 2", cyc); end
    total++; if (lo !== 32'd30) begin bad++; $display("FAIL rstmid_mul_lo: got %h want 0000001e", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL rstmid_mul_hi: got %h want 00000000", hi); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_divu;
    test_div_signed;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_sched.md
# mdu_sched

Shared multiply/divide sequencer for the dual-issue execute stage. The c and p execute pipes each present HI/LO-writing arithmetic (MULT, MULTU, DIV, DIVU) here instead of owning a private iterative unit. The block arbitrates between the two pipes, runs one operation at a time on a single multiplier/radix-2 restoring divider, and returns the 64-bit HI/LO result with a one-cycle done pulse. It generates per-pipe stall requests that the pipeline controller ORs into the EX stall.

## Interface
- MUL_LAT, 1, cycles spent in MUL state (legal 1..4); the product pipeline is retimed across them
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  exception/refetch flush; aborts any operation
- c_req  in  1  pipe c requests an operation; held until c_done
- c_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- c_src_a  in  32  rs operand (dividend / multiplicand)
- c_src_b  in  32  rt operand (divisor / multiplier)
- c_done  out  1  one-cycle pulse; hi_res/lo_res valid for pipe c
- c_stall_req  out  1  c_req & ~c_done
- p_req, p_op, p_src_a, p_src_b, p_done, p_stall_req  same as c_* for pipe p
- hi_res  out  32  HI result (product[63:32] / remainder)
- lo_res  out  32  LO result (product[31:0] / quotient)
- busy  out  1  state != IDLE
- owner  out  1  0 = pipe c, 1 = pipe p; valid while busy

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: flush has priority; no grant that cycle. Else c_req grants c (c is the older slot). Else p_req grants p. Grant latches op, operands, and owner. Next state is MUL if op[1]=0, otherwise DIV.
- MUL: 64-bit product. Signed (MULT) treats both operands as two's complement; MULTU treats them as unsigned. Stay MUL_LAT cycles, then DONE.
- DIV: On entry, take magnitudes if signed (DIV). Perform 32 iterations, one quotient bit per cycle, on a 6-bit counter 0..31. After the last iteration, apply sign correction: quotient is negated if the signs differ; remainder takes the dividend's sign. Then DONE.
- Divide by zero (src_b == 0, either signedness): still runs 32 cycles. Result is lo_res=32'hFFFF_FFFF, hi_res=src_a.
- 0x80000000 / -1 (DIV): lo_res=0x80000000, hi_res=0. Magnitudes wrap naturally.
- DONE: hi_res/lo_res registered and valid. Assert owner's done for exactly this cycle. Go to IDLE.
- hi_res/lo_res hold their last value until the next DONE.
- Requester protocol: req, op, and operands stay stable from request until done. Operands are latched at grant, so later changes are ignored but are illegal. The pipeline advances at the done edge. A new req may appear in the following (IDLE) cycle.
- A requester losing arbitration keeps req high. Its stall_req stays 1 until its own done.
- flush in any state: next state IDLE. No done is issued and hi_res/lo_res are unchanged. A flush in the same cycle as DONE still lets done assert; the consumer discards it.
- Reset (any time, including mid-operation): state IDLE; hi_res=0, lo_res=0, c_done=p_done=0, busy=0, owner=0, counter=0.

## Timing
- Grant in cycle 0 (IDLE sampled req).
- MUL: cycles 1..MUL_LAT; done at cycle MUL_LAT+1 (default 2).
- DIV: cycles 1..32; done at cycle 33.
- Back-to-back: DONE is followed by one IDLE cycle. The earliest next grant is the cycle after DONE.
- stall_req is combinational from req and done. It drops in the done cycle so EX captures the result that edge.
- done, hi_res, lo_res, busy, and owner are registered. Only the stall_req outputs are combinational.

## Test plan
- c MULT a=0xFFFFFFFE, b=3 → c_done at cycle 2. hi=0xFFFFFFFF, lo=0xFFFFFFFA. c_stall_req=1 in cycles 0–1 and 0 in cycle 2.
- p DIVU 100/7 → p_done at cycle 33. lo=14, hi=2. busy=1 in cycles 1–33 (1–32 DIV, 33 DONE).
- c DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also c DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Simultaneous c MULTU 0xFFFFFFFF×0xFFFFFFFF and p DIVU 10/0:
  - c granted; c_done at cycle 2 with hi=0xFFFFFFFE, lo=1.
  - p_stall_req held through cycle 2; p granted at cycle 3.
  - p_done at cycle 36 with lo=0xFFFFFFFF, hi=10.
- p DIV in progress, flush at cycle 10 → IDLE at cycle 11. No p_done, busy=0, hi/lo unchanged. c_req at cycle 11 → granted, correct result.
- rst low at cycle 15 of a DIV → immediately busy=0, hi=lo=0, no done. After release, a MULT 5×6 gives lo=30 and hi=0 at the normal latency.
